// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch stage
//
// Owns the architectural fetch PC, issues one word fetch at a time to the
// instruction memory, and hands one {ins, pc, nop} bundle at a time to the
// decode stage over a valid/ready handshake. A redirect restarts fetch at a
// new PC and discards any fetch already in flight.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_redirect(_pc)         restart fetch at i_redirect_pc
//   o_imem_req_valid/addr   fetch request to instruction memory
//   i_imem_req_ready        request accepted when high with valid
//   i_imem_rsp_valid/data   one-cycle response strobe and instruction word
//   i_imem_rsp_err          access fault for this response
//   o_post_valid            bundle valid to decode
//   i_post_ready            decode ready
//   o_ifu_ins/pc/nop        bundle: instruction, its PC, bubble flag
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter int                   CPU_WIDTH = 64,
   parameter int                   INS_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_redirect,
   input  logic [CPU_WIDTH-1:0] i_redirect_pc,
   output logic                 o_imem_req_valid,
   input  logic                 i_imem_req_ready,
   output logic [CPU_WIDTH-1:0] o_imem_addr,
   input  logic                 i_imem_rsp_valid,
   input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
   input  logic                 i_imem_rsp_err,
   output logic                 o_post_valid,
   input  logic                 i_post_ready,
   output logic [INS_WIDTH-1:0] o_ifu_ins,
   output logic [CPU_WIDTH-1:0] o_ifu_pc,
   output logic                 o_ifu_nop
);

   // Canonical bubble: addi x0, x0, 0
   localparam logic [INS_WIDTH-1:0] NOP_INS = INS_WIDTH'(32'h13);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e               state_q, state_d;
   logic [CPU_WIDTH-1:0] pc_q, pc_d;
   logic                 drop_q, drop_d;
   logic                 req_valid_q;
   logic                 post_valid_q;
   logic [INS_WIDTH-1:0] ins_q, ins_d;
   logic [CPU_WIDTH-1:0] bpc_q, bpc_d;
   logic                 nop_q, nop_d;

   // Request to (re)start fetch at go_pc; resolved into REQ or the
   // misaligned-HOLD path once the per-state decisions are made.
   logic                 go_req;
   logic [CPU_WIDTH-1:0] go_pc;

   logic accept;
   logic handshake;

   assign accept    = req_valid_q & i_imem_req_ready;
   assign handshake = post_valid_q & i_post_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      ins_d   = ins_q;
      bpc_d   = bpc_q;
      nop_d   = nop_q;
      go_req  = 1'b0;
      go_pc   = pc_q;

      unique case (state_q)
         S_IDLE: begin
            go_req = 1'b1;
            go_pc  = i_redirect ? i_redirect_pc : pc_q;
         end

         S_REQ: begin
            if (i_redirect) begin
               if (accept) begin
                  // Request already left: its response must be thrown away.
                  state_d = S_WAIT;
                  drop_d  = 1'b1;
                  pc_d    = i_redirect_pc;
               end else begin
                  // Withdraw the request and present the new address.
                  go_req = 1'b1;
                  go_pc  = i_redirect_pc;
               end
            end else if (accept) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (i_redirect) begin
               pc_d = i_redirect_pc;
               if (i_imem_rsp_valid) begin
                  drop_d = 1'b0;
                  go_req = 1'b1;
                  go_pc  = i_redirect_pc;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (i_imem_rsp_valid) begin
               if (drop_q) begin
                  drop_d = 1'b0;
                  go_req = 1'b1;
                  go_pc  = pc_q;
               end else begin
                  state_d = S_HOLD;
                  ins_d   = i_imem_rsp_err ? NOP_INS : i_imem_rsp_data;
                  bpc_d   = pc_q;
                  nop_d   = i_imem_rsp_err;
               end
            end
         end

         S_HOLD: begin
            if (i_redirect) begin
               go_req = 1'b1;
               go_pc  = i_redirect_pc;
            end else if (handshake) begin
               go_req = 1'b1;
               go_pc  = pc_q + CPU_WIDTH'(4);
            end
         end

         default: state_d = S_IDLE;
      endcase

      // A misaligned PC never reaches the bus: it becomes a bubble bundle.
      if (go_req) begin
         pc_d = go_pc;
         if (go_pc[1:0] != 2'b00) begin
            state_d = S_HOLD;
            ins_d   = NOP_INS;
            bpc_d   = go_pc;
            nop_d   = 1'b1;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         post_valid_q <= 1'b0;
         ins_q        <= '0;
         bpc_q        <= '0;
         nop_q        <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register
         // samples pre-edge values, independent of statement order.
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         req_valid_q  <= (state_d == S_REQ);
         post_valid_q <= (state_d == S_HOLD);
         ins_q        <= ins_d;
         bpc_q        <= bpc_d;
         nop_q        <= nop_d;
      end
   end

   assign o_imem_req_valid = req_valid_q;
   assign o_imem_addr      = pc_q;
   assign o_post_valid     = post_valid_q;
   assign o_ifu_ins        = ins_q;
   assign o_ifu_pc         = bpc_q;
   assign o_ifu_nop        = nop_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch -- self-checking bench for ifu_fetch
//
// Directed scenarios (reset, straight-line fetch, backpressure, redirects,
// fault, misalignment, async reset) followed by a randomized phase checked
// against a transaction-level model: the model tracks the fetch PC, whether
// a fetch is outstanding (and stale), and which bundle decode should see.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [63:0] RESET_PC = 64'h8000_0000;
   localparam logic [31:0] NOP_INS  = 32'h13;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_redirect;
   logic [63:0] i_redirect_pc;
   logic        o_imem_req_valid;
   logic        i_imem_req_ready;
   logic [63:0] o_imem_addr;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        i_imem_rsp_err;
   logic        o_post_valid;
   logic        i_post_ready;
   logic [31:0] o_ifu_ins;
   logic [63:0] o_ifu_pc;
   logic        o_ifu_nop;

   int n_total = 0;
   int n_bad   = 0;

   ifu_fetch #(
      .CPU_WIDTH(64),
      .INS_WIDTH(32),
      .RESET_PC (RESET_PC)
   ) dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_redirect      (i_redirect),
      .i_redirect_pc   (i_redirect_pc),
      .o_imem_req_valid(o_imem_req_valid),
      .i_imem_req_ready(i_imem_req_ready),
      .o_imem_addr     (o_imem_addr),
      .i_imem_rsp_valid(i_imem_rsp_valid),
      .i_imem_rsp_data (i_imem_rsp_data),
      .i_imem_rsp_err  (i_imem_rsp_err),
      .o_post_valid    (o_post_valid),
      .i_post_ready    (i_post_ready),
      .o_ifu_ins       (o_ifu_ins),
      .o_ifu_pc        (o_ifu_pc),
      .o_ifu_nop       (o_ifu_nop)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
   endtask

   task automatic check_bundle(input string tag, input logic [31:0] ins,
                               input logic [63:0] pc, input logic nop);
      check({tag, "_valid"}, o_post_valid, 1'b1);
      check({tag, "_ins"}, o_ifu_ins, ins);
      check({tag, "_pc"}, o_ifu_pc, pc);
      check({tag, "_nop"}, o_ifu_nop, nop);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, o_imem_req_valid, 1'b0);
      check({tag, "_addr"}, o_imem_addr, RESET_PC);
      check({tag, "_post_valid"}, o_post_valid, 1'b0);
      check({tag, "_ins"}, o_ifu_ins, 32'h0);
      check({tag, "_pc"}, o_ifu_pc, 64'h0);
      check({tag, "_nop"}, o_ifu_nop, 1'b0);
   endtask

   // Memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ 32'h5eed_1234;
   endfunction

   function automatic logic [63:0] pick_target();
      logic [63:0] t;
      case ($urandom_range(0, 7))
         5:       t = RESET_PC + 64'($urandom_range(0, 255) * 4) + 64'($urandom_range(1, 3));
         6:       t = 64'hFFFF_FFFF_FFFF_FFF8;
         default: t = RESET_PC + 64'($urandom_range(0, 255) * 4);
      endcase
      return t;
   endfunction

   // Transaction-level reference state
   logic [63:0] m_pc;       // PC of the next bundle decode should receive
   logic        m_out;      // a fetch is outstanding on the bus
   logic        m_stale;    // the outstanding fetch was overtaken by a redirect
   logic [63:0] m_oaddr;    // address of the outstanding fetch
   int          m_delay;    // cycles until the memory answers
   logic        m_have;     // a valid response is waiting to be handed off
   logic [63:0] m_raddr;
   logic        m_rerr;

   initial begin
      logic mis, exp_post, acc, hs, rsp_now, redir;
      logic [63:0] tgt;

      i_rst_n          = 1'b0;
      i_redirect       = 1'b0;
      i_redirect_pc    = '0;
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = '0;
      i_imem_rsp_err   = 1'b0;
      i_post_ready     = 1'b0;

      // ---------------- reset and straight-line fetch ----------------
      tick();
      tick();
      check_reset_outputs("reset");
      i_rst_n = 1'b1;
      tick();                                  // cycle 1: REQ
      check("c1_req_valid", o_imem_req_valid, 1'b1);
      check("c1_req_addr", o_imem_addr, 64'h8000_0000);
      check("c1_post_valid", o_post_valid, 1'b0);
      i_imem_req_ready = 1'b1;
      tick();                                  // cycle 2: WAIT
      check("c2_req_valid", o_imem_req_valid, 1'b0);
      check("c2_post_valid", o_post_valid, 1'b0);
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 32'h0010_0093;
      tick();                                  // cycle 3: HOLD
      i_imem_rsp_valid = 1'b0;
      check_bundle("c3_bundle", 32'h0010_0093, 64'h8000_0000, 1'b0);

      // ---------------- backpressure ----------------
      for (int i = 0; i < 5; i++) begin
         tick();
         check_bundle("bp_hold", 32'h0010_0093, 64'h8000_0000, 1'b0);
         check("bp_no_req", o_imem_req_valid, 1'b0);
      end
      i_post_ready = 1'b1;
      tick();
      i_post_ready = 1'b0;
      check("bp_next_req_valid", o_imem_req_valid, 1'b1);
      check("bp_next_req_addr", o_imem_addr, 64'h8000_0004);
      check("bp_next_post_valid", o_post_valid, 1'b0);

      // ---------------- redirect during WAIT ----------------
      i_imem_req_ready = 1'b1;
      tick();                                  // WAIT
      i_imem_req_ready = 1'b0;
      i_redirect       = 1'b1;
      i_redirect_pc    = 64'h8000_0100;
      tick();                                  // still WAIT, dropping
      i_redirect = 1'b0;
      check("rw_wait_req_valid", o_imem_req_valid, 1'b0);
      check("rw_wait_post_valid", o_post_valid, 1'b0);
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 32'hcafe_f00d;
      tick();
      i_imem_rsp_valid = 1'b0;
      check("rw_post_valid", o_post_valid, 1'b0);
      check("rw_req_valid", o_imem_req_valid, 1'b1);
      check("rw_req_addr", o_imem_addr, 64'h8000_0100);

      // ---------------- redirect colliding with response ----------------
      i_imem_req_ready = 1'b1;
      tick();                                  // WAIT
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = 32'h1111_2222;
      i_redirect       = 1'b1;
      i_redirect_pc    = 64'h8000_0100;
      tick();
      i_imem_rsp_valid = 1'b0;
      i_redirect       = 1'b0;
      check("rc_post_valid", o_post_valid, 1'b0);
      check("rc_req_valid", o_imem_req_valid, 1'b1);
      check("rc_req_addr", o_imem_addr, 64'h8000_0100);

      // ---------------- access fault ----------------
      i_imem_req_ready = 1'b1;
      tick();                                  // WAIT
      i_imem_req_ready = 1'b0;
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_err   = 1'b1;
      i_imem_rsp_data  = 32'hdead_beef;
      tick();
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_err   = 1'b0;
      check_bundle("fault", NOP_INS, 64'h8000_0100, 1'b1);

      // ---------------- misaligned redirect ----------------
      i_redirect    = 1'b1;
      i_redirect_pc = 64'h8000_0102;
      tick();
      i_redirect = 1'b0;
      check("mis_req_valid", o_imem_req_valid, 1'b0);
      check_bundle("mis", NOP_INS, 64'h8000_0102, 1'b1);
      i_post_ready = 1'b1;
      tick();
      i_post_ready = 1'b0;
      check("mis2_req_valid", o_imem_req_valid, 1'b0);
      check_bundle("mis2", NOP_INS, 64'h8000_0106, 1'b1);
      i_redirect    = 1'b1;
      i_redirect_pc = 64'h8000_0200;
      tick();
      i_redirect = 1'b0;
      check("realign_req_valid", o_imem_req_valid, 1'b1);
      check("realign_req_addr", o_imem_addr, 64'h8000_0200);
      check("realign_post_valid", o_post_valid, 1'b0);

      // ---------------- async reset in WAIT ----------------
      i_imem_req_ready = 1'b1;
      tick();                                  // WAIT
      i_imem_req_ready = 1'b0;
      #2 i_rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      tick();
      i_rst_n          = 1'b1;
      i_imem_rsp_valid = 1'b1;                 // stray response
      i_imem_rsp_data  = 32'h0bad_0bad;
      tick();
      i_imem_rsp_valid = 1'b0;
      check("stray_post_valid", o_post_valid, 1'b0);
      check("stray_req_valid", o_imem_req_valid, 1'b1);
      check("stray_req_addr", o_imem_addr, RESET_PC);
      tick();
      check("stray_post_valid2", o_post_valid, 1'b0);

      // ---------------- randomized phase ----------------
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();                                  // first request now visible
      m_pc    = RESET_PC;
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_oaddr = '0;
      m_delay = 0;
      m_have  = 1'b0;
      m_raddr = '0;
      m_rerr  = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         // compare DUT outputs with the model
         mis = (m_pc[1:0] != 2'b00);
         if (m_out) begin
            check("rnd_req_while_out", o_imem_req_valid, 1'b0);
            check("rnd_post_while_out", o_post_valid, 1'b0);
         end else begin
            exp_post = m_have | mis;
            check("rnd_post_valid", o_post_valid, exp_post);
            check("rnd_req_valid", o_imem_req_valid, !exp_post);
         end
         if (o_imem_req_valid)
            check("rnd_req_addr", o_imem_addr, m_pc);
         if (o_post_valid && !m_out) begin
            if (mis) begin
               check_bundle("rnd_mis", NOP_INS, m_pc, 1'b1);
            end else if (m_have) begin
               check_bundle("rnd_bundle", m_rerr ? NOP_INS : mem_word(m_raddr), m_raddr, m_rerr);
            end
         end

         // drive the next cycle's inputs
         i_post_ready     = ($urandom_range(0, 9) < 7);
         i_imem_req_ready = ($urandom_range(0, 9) < 7);
         rsp_now          = m_out && (m_delay == 0);
         i_imem_rsp_valid = rsp_now;
         i_imem_rsp_data  = rsp_now ? mem_word(m_oaddr) : 32'($urandom());
         i_imem_rsp_err   = ($urandom_range(0, 7) == 0);
         redir            = ($urandom_range(0, 19) == 0);
         tgt              = pick_target();
         i_redirect       = redir;
         i_redirect_pc    = tgt;

         // advance the model across the coming edge
         acc = o_imem_req_valid & i_imem_req_ready;
         hs  = o_post_valid & i_post_ready;
         if (hs) begin
            m_pc   = m_pc + 64'd4;
            m_have = 1'b0;
         end
         if (rsp_now) begin
            m_out = 1'b0;
            if (!m_stale && !redir) begin
               m_have  = 1'b1;
               m_raddr = m_oaddr;
               m_rerr  = i_imem_rsp_err;
            end
         end else if (m_out) begin
            m_delay--;
         end
         if (acc) begin
            m_out   = 1'b1;
            m_stale = 1'b0;
            m_oaddr = o_imem_addr;
            m_delay = $urandom_range(0, 2);
         end
         if (redir) begin
            m_pc   = tgt;
            m_have = 1'b0;
            if (m_out) m_stale = 1'b1;
         end

         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
